// File: rtl/mac_dot_seq.sv
// Dot-product sequencer for a registered 16-bit multiply-accumulate unit.
// Optional abort input when MAC_SEQ_ABORT_EN is defined.
module mac_dot_seq #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LEN_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef MAC_SEQ_ABORT_EN
  input  logic                 abort,
`endif
  input  logic                 start,
  input  logic [LEN_W-1:0]     cfg_len,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [2*WIDTH-1:0]   res_data,
  output logic                 res_ovf,
  output logic                 busy,
  output logic [WIDTH-1:0]     mac_a,
  output logic [WIDTH-1:0]     mac_b,
  output logic                 mac_rst,
  output logic                 mac_cin,
  input  logic [2*WIDTH-1:0]   mac_acc,
  input  logic                 mac_cout
);

  localparam int unsigned ACC_W = 2 * WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRAIN1,
    S_DRAIN2,
    S_RESULT
  } state_t;

  state_t             state, state_nxt;
  logic [LEN_W-1:0]   rem, rem_nxt;
  logic [WIDTH-1:0]   mac_a_nxt, mac_b_nxt;
  logic               mac_rst_nxt;
  logic               res_valid_nxt;
  logic               res_ovf_nxt;
  logic [ACC_W-1:0]   res_data_nxt;
  logic               in_fire;
  logic               res_fire;
  logic               abort_req;

  assign mac_cin  = 1'b0;
  // in_ready is registered high exactly while in RUN
  assign in_fire  = in_valid && in_ready;
  assign res_fire = res_valid && res_ready;

`ifdef MAC_SEQ_ABORT_EN
  assign abort_req = abort && (state != S_IDLE) && (state != S_RESULT);
`else
  assign abort_req = 1'b0;
`endif

  // Next-state and next-output logic; operands default to zero so idle cycles add nothing
  always_comb begin
    state_nxt     = state;
    rem_nxt       = rem;
    mac_a_nxt     = '0;
    mac_b_nxt     = '0;
    mac_rst_nxt   = 1'b0;
    res_valid_nxt = res_valid;
    res_data_nxt  = res_data;
    res_ovf_nxt   = res_ovf;

    case (state)
      S_IDLE: begin
        if (start) begin
          rem_nxt     = cfg_len;
          res_ovf_nxt = 1'b0;
          mac_rst_nxt = 1'b1;
          state_nxt   = S_CLEAR;
        end
      end
      S_CLEAR: begin
        state_nxt = (rem == '0) ? S_DRAIN1 : S_RUN;
      end
      S_RUN: begin
        res_ovf_nxt = res_ovf | mac_cout;
        if (in_fire) begin
          mac_a_nxt = in_a;
          mac_b_nxt = in_b;
          rem_nxt   = rem - LEN_W'(1);
          if (rem == LEN_W'(1)) state_nxt = S_DRAIN1;
        end
      end
      S_DRAIN1: begin
        res_ovf_nxt = res_ovf | mac_cout;
        state_nxt   = S_DRAIN2;
      end
      S_DRAIN2: begin
        res_ovf_nxt   = res_ovf | mac_cout;
        res_data_nxt  = mac_acc;
        res_valid_nxt = 1'b1;
        state_nxt     = S_RESULT;
      end
      S_RESULT: begin
        if (res_fire) begin
          res_valid_nxt = 1'b0;
          state_nxt     = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // Abort drops the job and clears the MAC for one cycle
    if (abort_req) begin
      state_nxt     = S_IDLE;
      mac_rst_nxt   = 1'b1;
      mac_a_nxt     = '0;
      mac_b_nxt     = '0;
      res_valid_nxt = 1'b0;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      rem       <= '0;
      mac_a     <= '0;
      mac_b     <= '0;
      mac_rst   <= 1'b1;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_ovf   <= 1'b0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      rem       <= rem_nxt;
      mac_a     <= mac_a_nxt;
      mac_b     <= mac_b_nxt;
      mac_rst   <= mac_rst_nxt;
      res_valid <= res_valid_nxt;
      res_data  <= res_data_nxt;
      res_ovf   <= res_ovf_nxt;
      in_ready  <= (state_nxt == S_RUN);
      busy      <= (state_nxt != S_IDLE);
    end
  end

endmodule

// File: tb/tb_mac_dot_seq.sv
// Self-checking bench for mac_dot_seq with a behavioural MAC attached.
module tb_mac_dot_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  cfg_len;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a, in_b;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_ovf;
  logic        busy;
  logic [15:0] mac_a, mac_b;
  logic        mac_rst;
  logic        mac_cin;
  logic [31:0] mac_acc;
  logic        mac_cout;
`ifdef MAC_SEQ_ABORT_EN
  logic        abort = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int ir_cnt = 0;

  logic [15:0] op_a [16];
  logic [15:0] op_b [16];

  mac_dot_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef MAC_SEQ_ABORT_EN
    .abort     (abort),
`endif
    .start     (start),
    .cfg_len   (cfg_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_ovf   (res_ovf),
    .busy      (busy),
    .mac_a     (mac_a),
    .mac_b     (mac_b),
    .mac_rst   (mac_rst),
    .mac_cin   (mac_cin),
    .mac_acc   (mac_acc),
    .mac_cout  (mac_cout)
  );

  always #5 clk = ~clk;

  // Registered multiply-accumulate unit driven by the sequencer
  logic [31:0] acc;
  logic [31:0] prod;
  logic [32:0] mac_sum;
  assign prod     = 32'(mac_a) * 32'(mac_b);
  assign mac_sum  = {1'b0, acc} + {1'b0, prod} + 33'(mac_cin);
  assign mac_cout = mac_sum[32];
  assign mac_acc  = acc;
  always @(posedge clk) begin
    if (mac_rst) acc <= '0;
    else         acc <= mac_sum[31:0];
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (in_ready) ir_cnt <= ir_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain sum of products; overflow iff the true sum needs more than 32 bits
  function automatic void model(input int len, output logic [31:0] d, output logic o);
    logic [63:0] s;
    s = '0;
    for (int i = 0; i < len; i++) s = s + 64'(op_a[i]) * 64'(op_b[i]);
    d = s[31:0];
    o = (s[63:32] != 32'd0);
  endfunction

  task automatic do_job(input int len, input int gap, input bit rand_gap, input int bp,
                        input logic [31:0] exp_data, input logic exp_ovf, input int exp_lat);
    int ref_cyc;
    int bound;
    int ir0;
    int g;
    @(negedge clk);
    chk("idle_busy", 64'(busy), 64'(0));
    start   = 1'b1;
    cfg_len = 8'(len);
    @(negedge clk);
    start   = 1'b0;
    ref_cyc = cyc;
    ir0     = ir_cnt;
    chk("busy_after_start", 64'(busy), 64'(1));
    chk("mac_rst_clear", 64'(mac_rst), 64'(1));
    for (int i = 0; i < len; i++) begin
      g = rand_gap ? int'($urandom_range(0, 3)) : gap;
      if (i > 0) begin
        for (int k = 0; k < g; k++) begin
          @(negedge clk);
          chk("gap_operands", 64'({mac_a, mac_b}), 64'(0));
        end
      end
      in_valid = 1'b1;
      in_a     = op_a[i];
      in_b     = op_b[i];
      bound    = 0;
      while (!in_ready && bound < 20) begin
        @(negedge clk);
        bound++;
      end
      chk("in_ready_seen", 64'(in_ready), 64'(1));
      @(negedge clk);
      ref_cyc  = cyc;
      in_valid = 1'b0;
      chk("mac_operand_load", 64'({mac_a, mac_b}), 64'({op_a[i], op_b[i]}));
    end
    bound = 0;
    while (!res_valid && bound < 20) begin
      @(negedge clk);
      bound++;
    end
    chk("res_valid_seen", 64'(res_valid), 64'(1));
    chk("res_latency", 64'(cyc - ref_cyc), 64'(exp_lat));
    chk("res_data", 64'(res_data), 64'(exp_data));
    chk("res_ovf", 64'(res_ovf), 64'(exp_ovf));
    if (len == 0) chk("no_in_ready", 64'(ir_cnt - ir0), 64'(0));
    // Backpressure: results must hold and a start pulse must be ignored
    for (int k = 0; k < bp; k++) begin
      start   = (k == 1);
      cfg_len = 8'd5;
      @(negedge clk);
      chk("hold_valid", 64'(res_valid), 64'(1));
      chk("hold_result", 64'({res_ovf, res_data}), 64'({exp_ovf, exp_data}));
    end
    start     = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("res_valid_drop", 64'(res_valid), 64'(0));
    chk("idle_after_result", 64'(busy), 64'(0));
  endtask

  typedef struct {
    int          len;
    int          gap;
    int          bp;
    logic [63:0] a;
    logic [63:0] b;
    logic [31:0] exp_data;
    logic        exp_ovf;
    int          exp_lat;
  } vec_t;

  vec_t vecs [5];

  initial begin
    logic [31:0] md;
    logic        mo;
    int          len;
    bit          big;

    vecs[0] = '{len: 3, gap: 0, bp: 0, a: {16'd0, 16'd6, 16'd4, 16'd2},
                b: {16'd0, 16'd7, 16'd5, 16'd3}, exp_data: 32'h0000_0044, exp_ovf: 1'b0, exp_lat: 2};
    vecs[1] = '{len: 3, gap: 2, bp: 1, a: {16'd0, 16'd6, 16'd4, 16'd2},
                b: {16'd0, 16'd7, 16'd5, 16'd3}, exp_data: 32'h0000_0044, exp_ovf: 1'b0, exp_lat: 2};
    vecs[2] = '{len: 0, gap: 0, bp: 0, a: 64'd0, b: 64'd0,
                exp_data: 32'h0000_0000, exp_ovf: 1'b0, exp_lat: 3};
    vecs[3] = '{len: 2, gap: 0, bp: 5, a: {16'd0, 16'd0, 16'hFFFF, 16'hFFFF},
                b: {16'd0, 16'd0, 16'hFFFF, 16'hFFFF}, exp_data: 32'hFFFC_0002, exp_ovf: 1'b1, exp_lat: 2};
    vecs[4] = '{len: 1, gap: 0, bp: 0, a: {16'd0, 16'd0, 16'd0, 16'd1},
                b: {16'd0, 16'd0, 16'd0, 16'd1}, exp_data: 32'h0000_0001, exp_ovf: 1'b0, exp_lat: 2};

    rst_n     = 1'b0;
    start     = 1'b0;
    cfg_len   = 8'd0;
    in_valid  = 1'b0;
    in_a      = 16'd0;
    in_b      = 16'd0;
    res_ready = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_mac_rst", 64'(mac_rst), 64'(1));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_res", 64'({res_valid, res_ovf, res_data}), 64'(0));
    chk("rst_operands", 64'({mac_a, mac_b}), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("mac_cin_zero", 64'(mac_cin), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("mac_rst_release", 64'(mac_rst), 64'(0));

    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < 4; i++) begin
        op_a[i] = vecs[v].a[i*16 +: 16];
        op_b[i] = vecs[v].b[i*16 +: 16];
      end
      do_job(vecs[v].len, vecs[v].gap, 1'b0, vecs[v].bp,
             vecs[v].exp_data, vecs[v].exp_ovf, vecs[v].exp_lat);
    end

    // Reset in the middle of a job
    @(negedge clk);
    start   = 1'b1;
    cfg_len = 8'd3;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    in_a     = 16'd9;
    in_b     = 16'd9;
    for (int k = 0; k < 5 && !in_ready; k++) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("midjob_busy", 64'(busy), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_mac_rst", 64'(mac_rst), 64'(1));
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_res_valid", 64'(res_valid), 64'(0));
    chk("midrst_operands", 64'({in_ready, mac_a, mac_b}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    op_a[0] = 16'd3;
    op_b[0] = 16'd3;
    do_job(1, 0, 1'b0, 0, 32'd9, 1'b0, 2);

    // Randomized jobs against the reference model
    for (int j = 0; j < 24; j++) begin
      len = int'($urandom_range(0, 10));
      big = ($urandom_range(0, 1) == 1);
      for (int i = 0; i < len; i++) begin
        op_a[i] = big ? 16'($urandom_range(16'hE000, 16'hFFFF)) : 16'($urandom);
        op_b[i] = big ? 16'($urandom_range(16'hE000, 16'hFFFF)) : 16'($urandom);
      end
      model(len, md, mo);
      do_job(len, 0, 1'b1, int'($urandom_range(0, 3)), md, mo, (len == 0) ? 3 : 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
